// File: rtl/controle_varredura_pkg.sv
// Shared state encoding of the sweep controller, also used by the debug display.
package controle_varredura_pkg;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        ESPERA    = 4'd2,
        MEDE      = 4'd3,
        AGUARDA   = 4'd4,
        TRANSMITE = 4'd5,
        AG_TX     = 4'd6,
        PROXIMO   = 4'd7,
        FIM       = 4'd8
    } estado_t;

endpackage

// File: rtl/controle_varredura_timer_ciclos.sv
// Cycle counter with synchronous clear, count enable and terminal-count flag.
module timer_ciclos #(
    parameter int NT    = 16,
    parameter int T_FIM = 50
) (
    input  logic clock,
    input  logic reset_n,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [NT-1:0] VALOR_FIM = NT'(T_FIM - 1);
    localparam logic [NT-1:0] UM        = NT'(1);

    logic [NT-1:0] valor;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + UM;
        end
    end

    // Equality compare is enough: the owner clears the timer whenever it leaves its state.
    assign fim = (valor == VALOR_FIM);

endmodule

// File: rtl/controle_varredura.sv
// Sweep sequencer: settle, measure, transmit, step the position counter; single or continuous.
module controle_varredura
    import controle_varredura_pkg::*;
#(
    parameter int T_ESPERA  = 50,
    parameter int T_TIMEOUT = 1000,
    parameter int NT        = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ligar,
    input  logic       modo_unico,
    input  logic       pos_inicio,
    input  logic       direcao,
    input  logic       pronto_medida,
    input  logic       fim_transmissao,
    output logic       zera_pos,
    output logic       conta_pos,
    output logic       medir,
    output logic       transmitir,
    output logic       pronto,
    output logic       erro_timeout,
    output logic [3:0] db_estado
);

    estado_t estado, proximo;
    logic    modo;
    logic    erro;
    logic    fim_espera;
    logic    fim_timeout;

    timer_ciclos #(.NT(NT), .T_FIM(T_ESPERA)) u_timer_espera (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (estado != ESPERA),
        .conta   (estado == ESPERA),
        .fim     (fim_espera)
    );

    timer_ciclos #(.NT(NT), .T_FIM(T_TIMEOUT)) u_timer_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (estado != AGUARDA),
        .conta   (estado == AGUARDA),
        .fim     (fim_timeout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Mode and sticky error are captured on leaving INICIAL; timeout loses to a same-cycle pronto_medida.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            modo <= 1'b0;
            erro <= 1'b0;
        end else if (estado == INICIAL && ligar) begin
            modo <= modo_unico;
            erro <= 1'b0;
        end else if (estado == AGUARDA && !pronto_medida && fim_timeout) begin
            erro <= 1'b1;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:   if (ligar) proximo = PREPARA;
            PREPARA:   proximo = ESPERA;
            ESPERA:    if (fim_espera) proximo = MEDE;
            MEDE:      proximo = AGUARDA;
            AGUARDA: begin
                if (pronto_medida)    proximo = TRANSMITE;
                else if (fim_timeout) proximo = PROXIMO;
            end
            TRANSMITE: proximo = AG_TX;
            AG_TX:     if (fim_transmissao) proximo = PROXIMO;
            PROXIMO: begin
                if (!ligar)                              proximo = INICIAL;
                else if (modo && pos_inicio && direcao)  proximo = FIM;
                else                                     proximo = ESPERA;
            end
            FIM:       if (!ligar) proximo = INICIAL;
            default:   proximo = INICIAL;
        endcase
    end

    always_comb begin
        zera_pos   = 1'b0;
        conta_pos  = 1'b0;
        medir      = 1'b0;
        transmitir = 1'b0;
        pronto     = 1'b0;
        case (estado)
            PREPARA:   zera_pos   = 1'b1;
            MEDE:      medir      = 1'b1;
            TRANSMITE: transmitir = 1'b1;
            PROXIMO:   conta_pos  = ligar && !(modo && pos_inicio && direcao);
            FIM:       pronto     = 1'b1;
            default:   ;
        endcase
    end

    assign erro_timeout = erro;
    assign db_estado    = estado;

endmodule

// File: tb/tb_controle_varredura.sv
// Bench for controle_varredura with a position-counter model and echoing measurement/transmit units.
module tb_controle_varredura;

    localparam int T_ESPERA  = 4;
    localparam int T_TIMEOUT = 10;
    localparam int NT        = 16;
    localparam int M         = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ligar = 1'b0;
    logic       modo_unico = 1'b0;
    logic       pos_inicio, direcao, pronto_medida, fim_transmissao;
    logic       zera_pos, conta_pos, medir, transmitir, pronto, erro_timeout;
    logic [3:0] db_estado;

    controle_varredura #(.T_ESPERA(T_ESPERA), .T_TIMEOUT(T_TIMEOUT), .NT(NT)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ligar           (ligar),
        .modo_unico      (modo_unico),
        .pos_inicio      (pos_inicio),
        .direcao         (direcao),
        .pronto_medida   (pronto_medida),
        .fim_transmissao (fim_transmissao),
        .zera_pos        (zera_pos),
        .conta_pos       (conta_pos),
        .medir           (medir),
        .transmitir      (transmitir),
        .pronto          (pronto),
        .erro_timeout    (erro_timeout),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    // Up/down position counter: turns around at the ends, keeping the old direction for one position.
    int   pos = 0;
    logic dir_m = 1'b0;
    always @(posedge clock) begin
        if (zera_pos) begin
            pos   <= 0;
            dir_m <= 1'b0;
        end else if (conta_pos) begin
            if (!dir_m) begin
                if (pos == M - 1) begin
                    dir_m <= 1'b1;
                    pos   <= pos - 1;
                end else begin
                    pos <= pos + 1;
                end
            end else begin
                if (pos == 0) begin
                    dir_m <= 1'b0;
                    pos   <= pos + 1;
                end else begin
                    pos <= pos - 1;
                end
            end
        end
    end
    assign pos_inicio = (pos == 0);
    assign direcao    = dir_m;

    // Responders: a delay of 0 means the pulse never comes.
    int atraso_m = 3;
    int atraso_t = 3;
    int cnt_m = 0;
    int cnt_t = 0;
    always @(posedge clock) begin
        if (medir)          cnt_m <= atraso_m;
        else if (cnt_m > 0) cnt_m <= cnt_m - 1;
        if (transmitir)     cnt_t <= atraso_t;
        else if (cnt_t > 0) cnt_t <= cnt_t - 1;
    end
    assign pronto_medida   = (cnt_m == 1);
    assign fim_transmissao = (cnt_t == 1);

    int   n_medir = 0, n_conta = 0, n_tx = 0, n_fim = 0;
    logic sb_on = 1'b0;
    int   sb_q[$];
    int   exp_pos;
    always @(negedge clock) begin
        if (medir) begin
            n_medir <= n_medir + 1;
            if (sb_on) begin
                if (sb_q.size() == 0) begin
                    check("sb_medir_extra", 1, 0);
                end else begin
                    exp_pos = sb_q.pop_front();
                    check("sb_pos_medida", pos, exp_pos);
                end
            end
        end
        if (conta_pos)         n_conta <= n_conta + 1;
        if (transmitir)        n_tx    <= n_tx + 1;
        if (db_estado == 4'd8) n_fim   <= n_fim + 1;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_estado(input logic [3:0] alvo, input int limite, input string nome);
        int i = 0;
        while (db_estado !== alvo && i < limite) begin
            tick();
            i++;
        end
        check(nome, db_estado, alvo);
    endtask

    typedef struct {
        logic       ligar;
        logic [3:0] estado;
        logic       zera;
        logic       medir;
    } vetor_t;
    vetor_t tab[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_medir, s_conta, s_tx, s_fim, k;
        logic erro_cedo;

        tab[0] = '{1'b1, 4'd0, 1'b0, 1'b0};
        tab[1] = '{1'b1, 4'd1, 1'b1, 1'b0};
        tab[2] = '{1'b1, 4'd2, 1'b0, 1'b0};
        tab[3] = '{1'b1, 4'd2, 1'b0, 1'b0};
        tab[4] = '{1'b1, 4'd2, 1'b0, 1'b0};
        tab[5] = '{1'b1, 4'd2, 1'b0, 1'b0};
        tab[6] = '{1'b1, 4'd3, 1'b0, 1'b1};
        tab[7] = '{1'b1, 4'd4, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst_estado", db_estado, 0);
        check("rst_saidas", {zera_pos, conta_pos, medir, transmitir, pronto, erro_timeout}, 0);
        reset_n = 1'b1;
        tick();
        check("pos_rst_estado", db_estado, 0);

        // Settle timing followed by a full single sweep
        modo_unico = 1'b1;
        sb_q = '{0, 1, 2, 3, 2, 1, 0};
        sb_on = 1'b1;
        s_medir = n_medir; s_conta = n_conta; s_tx = n_tx;
        for (int i = 0; i < 8; i++) begin
            ligar = tab[i].ligar;
            check($sformatf("tab%0d_estado", i), db_estado, tab[i].estado);
            check($sformatf("tab%0d_zera", i), zera_pos, tab[i].zera);
            check($sformatf("tab%0d_medir", i), medir, tab[i].medir);
            tick();
        end
        wait_estado(4'd8, 1500, "sweep_fim");
        check("sweep_n_medir", n_medir - s_medir, 7);
        check("sweep_n_conta", n_conta - s_conta, 6);
        check("sweep_n_tx", n_tx - s_tx, 7);
        check("sweep_pronto", pronto, 1);
        check("sweep_pos_inicio", pos_inicio, 1);
        check("sweep_direcao", direcao, 1);
        check("sweep_sb_vazio", sb_q.size(), 0);
        check("sweep_erro", erro_timeout, 0);
        repeat (5) tick();
        check("fim_permanece", db_estado, 8);
        sb_on = 1'b0;
        ligar = 1'b0;
        tick();
        check("fim_para_inicial", db_estado, 0);
        check("fim_pronto_baixo", pronto, 0);

        // Timeout, then stop during AG_TX
        modo_unico = 1'b0;
        atraso_m = 0;
        ligar = 1'b1;
        wait_estado(4'd3, 50, "to_mede");
        s_tx = n_tx;
        tick();
        k = 0;
        erro_cedo = 1'b0;
        while (db_estado == 4'd4 && k < T_TIMEOUT + 5) begin
            if (erro_timeout) erro_cedo = 1'b1;
            tick();
            k++;
        end
        check("to_ciclos_aguarda", k, T_TIMEOUT);
        check("to_erro_cedo", erro_cedo, 0);
        check("to_proximo", db_estado, 7);
        check("to_erro", erro_timeout, 1);
        check("to_conta", conta_pos, 1);
        check("to_sem_tx", n_tx - s_tx, 0);
        atraso_m = 3;
        wait_estado(4'd6, 100, "to_ag_tx");
        check("to_erro_sticky", erro_timeout, 1);
        ligar = 1'b0;
        s_conta = n_conta;
        wait_estado(4'd0, 50, "stop_inicial");
        check("stop_sem_conta", n_conta - s_conta, 0);
        check("stop_erro_sticky", erro_timeout, 1);
        ligar = 1'b1;
        tick();
        check("reinicio_prepara", db_estado, 1);
        check("reinicio_erro_limpo", erro_timeout, 0);

        // pronto_medida on the terminal timeout cycle
        atraso_m = T_TIMEOUT;
        wait_estado(4'd3, 50, "race_mede");
        tick();
        k = 0;
        while (db_estado == 4'd4 && k < T_TIMEOUT + 5) begin
            tick();
            k++;
        end
        check("race_ciclos", k, T_TIMEOUT);
        check("race_transmite", db_estado, 5);
        check("race_sem_erro", erro_timeout, 0);
        atraso_m = 3;

        // Continuous mode: no FIM over more than three round trips
        s_conta = n_conta;
        s_fim = n_fim;
        k = 0;
        while (n_conta - s_conta < 20 && k < 3000) begin
            tick();
            k++;
        end
        check("cont_passos", (n_conta - s_conta) >= 20, 1);
        check("cont_sem_fim", n_fim - s_fim, 0);

        // Asynchronous reset in AGUARDA
        wait_estado(4'd4, 100, "rst_aguarda");
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_estado", db_estado, 0);
        check("arst_saidas", {zera_pos, conta_pos, medir, transmitir, pronto, erro_timeout}, 0);
        tick();
        tick();
        check("arst_mantido", db_estado, 0);
        reset_n = 1'b1;
        tick();
        check("arst_retoma_prepara", db_estado, 1);
        wait_estado(4'd3, 20, "arst_retoma_mede");
        check("arst_erro", erro_timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
